// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//   Multi-read-port general purpose register file for the MIPS datapath.
//   Read addresses come from decode; the single write port comes from
//   writeback. A hardware clear sequencer zeroes one entry per clock after
//   reset, or when clr is requested. While it runs, busy holds the pipeline
//   off, reads return zero and writes are discarded.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   NUM_RD    number of independent combinational read ports (>= 1)
//   ZERO_REG  1: entry 0 is hard-wired to zero, 0: ordinary register
//   BYPASS    1: same-cycle write data is forwarded to matching read ports
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   we       write enable
//   wa       write address
//   wd       write data
//   ra       packed read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd       packed read data,      port i = rd[i*DATA_W +: DATA_W]
//   clr      clear sweep request, only honoured while idle
//   busy     high while the clear sweep is running
//   wr_drop  one-cycle pulse, a write was discarded on the previous edge
// -----------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     clr,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptrNext;
    logic                r_wrDrop;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_busy;
    logic                w_memWe;
    logic [ADDR_W-1:0]   w_memAddr;
    logic [DATA_W-1:0]   w_memData;

    assign w_busy  = (r_state == S_CLEAR);
    assign busy    = w_busy;
    assign wr_drop = r_wrDrop;

    // Reset drops straight into the sweep, so the array needs no reset of its
    // own: the sequencer zeroes it one entry per edge starting at entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_CLEAR;
            r_ptr    <= '0;
            r_wrDrop <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_ptr    <= w_ptrNext;
            r_wrDrop <= we && w_busy;
        end
    end

    // The sweep and the writeback port share one physical write port: the
    // sweep owns it while clearing, writeback owns it while idle. A clr in the
    // clear state is ignored so a running sweep is never restarted.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_memWe     = 1'b0;
        w_memAddr   = wa;
        w_memData   = wd;
        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_stateNext = S_CLEAR;
                    w_ptrNext   = '0;
                end
                if (we && !((ZERO_REG != 0) && (wa == '0))) begin
                    w_memWe = 1'b1;
                end
            end
            S_CLEAR: begin
                w_memWe   = 1'b1;
                w_memAddr = r_ptr;
                w_memData = '0;
                w_ptrNext = r_ptr + ADDR_W'(1);
                if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    // Each read port resolves independently. The busy check comes first so
    // half-cleared contents are never exposed, and the zero-register check
    // precedes the bypass so a discarded write to entry 0 is never forwarded.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rdPort;

        assign w_ra     = ra[g*ADDR_W +: ADDR_W];
        assign w_rdPort = w_busy                               ? '0 :
                          ((ZERO_REG != 0) && (w_ra == '0))    ? '0 :
                          ((BYPASS != 0) && we && (wa == w_ra)) ? wd :
                          r_mem[w_ra];
        assign rd[g*DATA_W +: DATA_W] = w_rdPort;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
//   Directed bench for register_file_mp. dut uses the default parameters
//   (zero register, bypass, two read ports). dut2 uses four read ports with
//   bypass off and entry 0 as an ordinary register; it shares the clock,
//   reset and write/clear inputs with dut.
// -----------------------------------------------------------------------------
module tb_register_file_mp;

    logic         clk;
    logic         rst;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic         clr;
    logic [9:0]   ra;
    logic [63:0]  rd;
    logic         busy;
    logic         wrDrop;
    logic [19:0]  ra2;
    logic [127:0] rd2;
    logic         busy2;
    logic         wrDrop2;

    int checkCount;
    int passCount;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp2p0;
        logic [31:0] exp2p3;
    } vec_t;

    vec_t vecs [9];

    register_file_mp dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra      (ra),
        .rd      (rd),
        .clr     (clr),
        .busy    (busy),
        .wr_drop (wrDrop)
    );

    register_file_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (4),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra      (ra2),
        .rd      (rd2),
        .clr     (clr),
        .busy    (busy2),
        .wr_drop (wrDrop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and let the
    // combinational read paths settle before the caller checks.
    // dut2 ports: 0 = ra0, 1 = ra1, 2 = ra0, 3 = entry 0.
    task automatic applyStimulus(input logic iWe, input logic [4:0] iWa,
                                 input logic [31:0] iWd, input logic [4:0] iRa0,
                                 input logic [4:0] iRa1);
        @(negedge clk);
        we  = iWe;
        wa  = iWa;
        wd  = iWd;
        ra  = {iRa1, iRa0};
        ra2 = {5'd0, iRa0, iRa1, iRa0};
        #1;
    endtask

    // Count rising edges until busy falls on each DUT, starting from an
    // already-elapsed count. Bounded so a stuck sweep still reaches the end.
    task automatic sweepCount(input string name, input int startN);
        int n;
        int n1;
        int n2;
        n  = startN;
        n1 = 0;
        n2 = 0;
        while ((n1 == 0 || n2 == 0) && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
            if (!busy && n1 == 0) n1 = n;
            if (!busy2 && n2 == 0) n2 = n;
        end
        if (n1 == 0) n1 = n;
        if (n2 == 0) n2 = n;
        checkOutput({name, " dut edges"}, n1, 32);
        checkOutput({name, " dut2 edges"}, n2, 32);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst = 1'b0;
        we  = 1'b0;
        wa  = '0;
        wd  = '0;
        clr = 1'b0;
        ra  = '0;
        ra2 = '0;

        //                 we   wa     wd            ra0    ra1    exp0          exp1          exp2p0        exp2p3
        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd8,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd7,  32'h12345678, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'h12345678, 32'h0,        32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd8,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 5'd3,  32'hAAAA5555, 5'd3,  5'd3,  32'hAAAA5555, 32'hAAAA5555, 32'h12345678, 32'hFFFFFFFF};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd31, 32'hAAAA5555, 32'h0,        32'hAAAA5555, 32'hFFFFFFFF};
        vecs[7] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd30, 32'h00000001, 32'h0,        32'h0,        32'hFFFFFFFF};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h00000001, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};

        // Reset held for three cycles, then the power-on sweep.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd1);
        checkOutput("reset wr_drop", {31'd0, wrDrop}, 32'd0);
        checkOutput("reset rd0", rd[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        sweepCount("power-on sweep", 0);
        checkOutput("idle wr_drop", {31'd0, wrDrop}, 32'd0);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            checkOutput($sformatf("cleared rd0 a%0d", i), rd[31:0], 32'h0);
            checkOutput($sformatf("cleared rd1 a%0d", 31 - i), rd[63:32], 32'h0);
            checkOutput($sformatf("cleared dut2 a%0d", i), rd2[31:0], 32'h0);
        end

        // Table-driven writes, bypass and zero-register behaviour.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
            checkOutput($sformatf("vec%0d rd0", v), rd[31:0], vecs[v].exp0);
            checkOutput($sformatf("vec%0d rd1", v), rd[63:32], vecs[v].exp1);
            checkOutput($sformatf("vec%0d dut2 p0", v), rd2[31:0], vecs[v].exp2p0);
            checkOutput($sformatf("vec%0d dut2 p3", v), rd2[127:96], vecs[v].exp2p3);
            checkOutput($sformatf("vec%0d busy", v), {31'd0, busy}, 32'd0);
            checkOutput($sformatf("vec%0d wr_drop", v), {31'd0, wrDrop}, 32'd0);
        end

        // Fill entries 1..4, then clear on request with a write during the sweep.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h1000 + 32'(i), 5'(i), 5'd31);
            checkOutput($sformatf("fill bypass a%0d", i), rd[31:0], 32'h1000 + 32'(i));
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd1);
        checkOutput("fill a4", rd[31:0], 32'h00001004);
        checkOutput("fill a1", rd[63:32], 32'h00001001);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        we = 1'b1;
        wa = 5'd5;
        wd = 32'h55555555;
        #1;
        checkOutput("clr busy", {31'd0, busy}, 32'd1);
        checkOutput("busy read a4", rd[31:0], 32'h0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        we  = 1'b0;
        #1;
        checkOutput("drop pulse", {31'd0, wrDrop}, 32'd1);
        checkOutput("drop busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("drop cleared", {31'd0, wrDrop}, 32'd0);
        sweepCount("clr sweep", 2);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'd7);
            checkOutput($sformatf("post-clr a%0d", i), rd[31:0], 32'h0);
            checkOutput("post-clr a7", rd[63:32], 32'h0);
        end

        // Reset asserted with the sweep pointer at 10 restarts the sweep.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid-sweep reset busy", {31'd0, busy}, 32'd1);
        checkOutput("mid-sweep reset busy2", {31'd0, busy2}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sweepCount("restarted sweep", 0);

        // Write then read one entry on all four ports of dut2.
        applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
        checkOutput("dut2 no bypass", rd2[31:0], 32'h0);
        @(negedge clk);
        we  = 1'b0;
        ra2 = {4{5'd9}};
        ra  = {5'd9, 5'd9};
        #1;
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("dut2 port%0d a9", p), rd2[p*32 +: 32], 32'hCAFEF00D);
        end
        checkOutput("dut rd0 a9", rd[31:0], 32'hCAFEF00D);
        checkOutput("dut rd1 a9", rd[63:32], 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
